msx_bus_initiator: RTL

- Clocked MSX/Z80 slot-bus cycle generator. It is the host-side counterpart of the cartridge logic, which decodes CH376 I/O ports and the SCC-style ROM mapper.
- It turns single-word requests from a test harness or soft-CPU into properly sequenced IORQ/MREQ/SLTSL/RD/WR bus cycles, and honours WAIT.
- It is used to exercise and bring up the cartridge: CH376 ports 10h/11h/20h/21h, and mapper bank writes at 5000h/7000h/9000h/B000h.

---
 rtl/msx_bus_initiator.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/msx_bus_initiator.sv
// -----------------------------------------------------------------------------
// msx_bus_initiator
//
// Host-side MSX/Z80 slot-bus cycle generator. Each accepted single-word request
// becomes one IORQ (I/O) or MREQ+SLTSL (memory) read/write cycle, sequenced as
// IDLE -> SETUP -> STROBE -> HOLD -> RESP -> IDLE. An 8-bit down-counter times
// every phase, and the strobe phase is stretched while wait_n is low. If the
// stretch reaches WAIT_MAX cycles, the cycle is aborted with rsp_err set.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   req_valid/req_ready     request handshake (accepted on an edge with both high)
//   req_io/req_write        cycle type (I/O vs memory, write vs read)
//   req_addr/req_wdata      bus address and write data
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata/rsp_err       read data (00h for writes) and WAIT-timeout flag
//   a, d_out, d_oe, d_in    address bus, data bus out/enable, data bus in
//   iorq_n..wr_n            active-low bus strobes
//   wait_n                  active-low bus wait, synchronous to clk
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module msx_bus_initiator #(
  parameter int unsigned T_SETUP  = 1,
  parameter int unsigned T_STROBE = 2,
  parameter int unsigned T_HOLD   = 1,
  parameter int unsigned WAIT_MAX = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_io,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  output logic        iorq_n,
  output logic        mreq_n,
  output logic        sltsl_n,
  output logic        rd_n,
  output logic        wr_n,
  input  logic        wait_n
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Counter reload values; each phase lasts (load + 1) cycles.
  localparam logic [7:0] SETUP_LOAD  = 8'(T_SETUP - 1);
  localparam logic [7:0] STROBE_LOAD = 8'(T_STROBE - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(T_HOLD - 1);
  localparam logic [7:0] WAIT_LIMIT  = 8'(WAIT_MAX);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  wcnt_q;
  logic        io_q;
  logic        write_q;
  logic [7:0]  rdata_q;
  logic        err_q;

  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_rdata_q;
  logic        rsp_err_q;
  logic [15:0] a_q;
  logic [7:0]  d_out_q;
  logic        d_oe_q;
  logic        iorq_n_q;
  logic        mreq_n_q;
  logic        sltsl_n_q;
  logic        rd_n_q;
  logic        wr_n_q;

  // Bus-cycle sequencer: state, phase timers and every registered output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'h00;
      wcnt_q      <= 8'h00;
      io_q        <= 1'b0;
      write_q     <= 1'b0;
      rdata_q     <= 8'h00;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      a_q         <= 16'h0000;
      d_out_q     <= 8'h00;
      d_oe_q      <= 1'b0;
      iorq_n_q    <= 1'b1;
      mreq_n_q    <= 1'b1;
      sltsl_n_q   <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          d_oe_q <= 1'b0;
          if (req_valid && req_ready_q) begin
            io_q        <= req_io;
            write_q     <= req_write;
            a_q         <= req_addr;
            // Read cycles leave d_out untouched; only d_oe matters to the bus.
            d_out_q     <= req_write ? req_wdata : d_out_q;
            d_oe_q      <= req_write;
            rdata_q     <= 8'h00;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            cnt_q       <= SETUP_LOAD;
            state_q     <= ST_SETUP;
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        ST_SETUP: begin
          if (cnt_q == 8'h00) begin
            // Strobes assert only after address/data were stable for SETUP.
            iorq_n_q  <= ~io_q;
            mreq_n_q  <= io_q;
            sltsl_n_q <= io_q;
            rd_n_q    <= write_q;
            wr_n_q    <= ~write_q;
            cnt_q     <= STROBE_LOAD;
            wcnt_q    <= 8'h00;
            state_q   <= ST_STROBE;
          end else begin
            cnt_q <= cnt_q - 8'h01;
          end
        end

        ST_STROBE: begin
          if (cnt_q != 8'h00) begin
            // Minimum strobe width: wait_n is not looked at yet.
            cnt_q <= cnt_q - 8'h01;
          end else if (wait_n) begin
            rdata_q   <= write_q ? 8'h00 : d_in;
            iorq_n_q  <= 1'b1;
            mreq_n_q  <= 1'b1;
            sltsl_n_q <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            cnt_q     <= HOLD_LOAD;
            state_q   <= ST_HOLD;
          end else if (wcnt_q == WAIT_LIMIT) begin
            // Target held WAIT too long: release the bus, rdata stays 00h.
            err_q     <= 1'b1;
            iorq_n_q  <= 1'b1;
            mreq_n_q  <= 1'b1;
            sltsl_n_q <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            cnt_q     <= HOLD_LOAD;
            state_q   <= ST_HOLD;
          end else begin
            wcnt_q <= wcnt_q + 8'h01;
          end
        end

        ST_HOLD: begin
          if (cnt_q == 8'h00) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_q;
            rsp_err_q   <= err_q;
            d_oe_q      <= 1'b0;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 8'h01;
          end
        end

        ST_RESP: begin
          rsp_rdata_q <= 8'h00;
          rsp_err_q   <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end

        default: begin
          iorq_n_q    <= 1'b1;
          mreq_n_q    <= 1'b1;
          sltsl_n_q   <= 1'b1;
          rd_n_q      <= 1'b1;
          wr_n_q      <= 1'b1;
          d_oe_q      <= 1'b0;
          req_ready_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign a         = a_q;
  assign d_out     = d_out_q;
  assign d_oe      = d_oe_q;
  assign iorq_n    = iorq_n_q;
  assign mreq_n    = mreq_n_q;
  assign sltsl_n   = sltsl_n_q;
  assign rd_n      = rd_n_q;
  assign wr_n      = wr_n_q;

endmodule
